dcdc_sequencer: RTL

DCDC_SEQUENCER -- requirements
Module: dcdc_sequencer

---
 rtl/dcdc_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/dcdc_sequencer.sv
// DC-DC soft-start / protection sequencer with ramped setpoint and OV/OC fault handling.
// Define DCDC_SEQ_AUTORETRY_EN to enable cooldown-and-retry after faults.
module dcdc_sequencer #(
  parameter int unsigned RAMP_STEP    = 16,
  parameter int unsigned RAMP_DIV     = 256,
  parameter int unsigned OV_MARGIN    = 512,
  parameter int unsigned OC_FILTER    = 8,
  parameter int unsigned PGOOD_TOL    = 64,
  parameter int unsigned COOLDOWN_CYC = 65535,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] voltageTarget,
  input  logic [15:0] currentLimit,
  input  logic [15:0] vsense,
  input  logic [15:0] csense,
  output logic [15:0] voltageSet,
  output logic [15:0] currentSet,
  output logic        pgood,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SOFTSTART = 3'd1,
    S_REGULATE  = 3'd2,
    S_FAULT     = 3'd3,
    S_COOLDOWN  = 3'd4,
    S_LATCHED   = 3'd5
  } state_t;

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int OC_W  = $clog2(OC_FILTER + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [OC_W-1:0]  OC_LAST  = OC_W'(OC_FILTER - 1);
  localparam logic [OC_W-1:0]  OC_MAX   = OC_W'(OC_FILTER);
  localparam logic [16:0]      STEP17   = 17'(RAMP_STEP);
  localparam logic [16:0]      OVM17    = 17'(OV_MARGIN);
  localparam logic [15:0]      TOL16    = 16'(PGOOD_TOL);

`ifdef DCDC_SEQ_AUTORETRY_EN
  localparam int CD_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYC - 1);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);

  logic [CD_W-1:0] r_cd;
  logic [CD_W-1:0] w_cd_nxt;
  logic [RT_W-1:0] r_retry;
  logic [RT_W-1:0] w_retry_nxt;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_vset;
  logic [15:0]     r_iset;
  logic            r_pgood;
  logic            r_fault;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [OC_W-1:0] r_oc;
  logic [OC_W-1:0] w_oc_nxt;
  logic [OC_W-1:0] w_oc_cnt;
  logic [15:0]     w_vset_nxt;
  logic [16:0]     w_sum;
  logic [15:0]     w_ramp;
  logic [15:0]     w_diff;
  logic            w_win;
  logic            w_ov;
  logic            w_oc_hit;
  logic            w_oc_trip;
  logic            w_wrap;
  logic            w_trip;

  // 17-bit arithmetic keeps the ramp and OV threshold free of wrap-around
  assign w_sum  = {1'b0, r_vset} + STEP17;
  assign w_ramp = (w_sum > {1'b0, voltageTarget}) ? voltageTarget
                                                  : w_sum[15:0];
  assign w_ov   = {1'b0, vsense} > ({1'b0, voltageTarget} + OVM17);

  assign w_oc_hit  = csense > currentLimit;
  assign w_oc_trip = w_oc_hit && (r_oc >= OC_LAST);
  assign w_oc_cnt  = !w_oc_hit        ? '0 :
                     (r_oc == OC_MAX) ? r_oc :
                                        r_oc + 1'b1;
  assign w_trip    = w_ov || w_oc_trip;

  assign w_diff = (vsense >= voltageTarget) ? vsense - voltageTarget
                                            : voltageTarget - vsense;
  assign w_win  = w_diff <= TOL16;
  assign w_wrap = r_div == DIV_LAST;

  always_comb begin
    w_next     = r_state;
    w_vset_nxt = r_vset;
    w_div_nxt  = '0;
    w_oc_nxt   = '0;
`ifdef DCDC_SEQ_AUTORETRY_EN
    w_cd_nxt    = '0;
    w_retry_nxt = r_retry;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_vset_nxt = '0;
        if (enable) w_next = S_SOFTSTART;
      end
      S_SOFTSTART: begin
        w_oc_nxt = w_oc_cnt;
        if (w_trip) begin
          w_next     = S_FAULT;
          w_vset_nxt = '0;
        end else if (r_vset == voltageTarget) begin
          w_next = S_REGULATE;
        end else begin
          w_div_nxt = w_wrap ? '0 : r_div + 1'b1;
          if (w_wrap) w_vset_nxt = w_ramp;
        end
      end
      S_REGULATE: begin
        w_oc_nxt = w_oc_cnt;
        if (w_trip) begin
          w_next     = S_FAULT;
          w_vset_nxt = '0;
        end else if (voltageTarget > r_vset) begin
          w_next = S_SOFTSTART;
        end else if (voltageTarget < r_vset) begin
          w_vset_nxt = voltageTarget;
        end
      end
      S_FAULT: begin
        w_vset_nxt = '0;
`ifdef DCDC_SEQ_AUTORETRY_EN
        if (r_retry < RT_MAX) begin
          w_next      = S_COOLDOWN;
          w_retry_nxt = r_retry + 1'b1;
        end else begin
          w_next = S_LATCHED;
        end
`else
        w_next = S_LATCHED;
`endif
      end
      S_COOLDOWN: begin
        w_vset_nxt = '0;
`ifdef DCDC_SEQ_AUTORETRY_EN
        if (r_cd == CD_LAST) w_next = S_SOFTSTART;
        else w_cd_nxt = r_cd + 1'b1;
`else
        w_next = S_LATCHED;
`endif
      end
      S_LATCHED: begin
        w_vset_nxt = '0;
      end
      default: begin
        w_next     = S_IDLE;
        w_vset_nxt = '0;
      end
    endcase
    // dropping enable wins over everything, including same-cycle faults
    if (!enable) begin
      w_next     = S_IDLE;
      w_vset_nxt = '0;
      w_div_nxt  = '0;
      w_oc_nxt   = '0;
`ifdef DCDC_SEQ_AUTORETRY_EN
      w_cd_nxt    = '0;
      w_retry_nxt = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vset  <= '0;
      r_iset  <= '0;
      r_pgood <= 1'b0;
      r_fault <= 1'b0;
      r_div   <= '0;
      r_oc    <= '0;
`ifdef DCDC_SEQ_AUTORETRY_EN
      r_cd    <= '0;
      r_retry <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_vset  <= w_vset_nxt;
      r_iset  <= (w_next == S_SOFTSTART || w_next == S_REGULATE)
                 ? currentLimit : '0;
      r_pgood <= (w_next == S_REGULATE) && w_win;
      r_fault <= (w_next == S_FAULT) || (w_next == S_COOLDOWN) ||
                 (w_next == S_LATCHED);
      r_div   <= w_div_nxt;
      r_oc    <= w_oc_nxt;
`ifdef DCDC_SEQ_AUTORETRY_EN
      r_cd    <= w_cd_nxt;
      r_retry <= w_retry_nxt;
`endif
    end
  end

  assign voltageSet = r_vset;
  assign currentSet = r_iset;
  assign pgood      = r_pgood;
  assign fault      = r_fault;
  assign state      = r_state;

endmodule
